// File: rtl/rv32i_hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline status in, stall/flush/redirect controls
// and performance counters out.
interface rv32i_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      id_iw;
  logic [31:0]      ex_iw;
  logic             ex_wb_en;
  logic             ex_br_taken;
  logic [31:0]      ex_br_target;
  logic             mem_busy;
  logic             pc_stall;
  logic             ifid_stall;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             pipe_freeze;
  logic             pc_load;
  logic [31:0]      pc_target;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [1:0]       state_o;

  modport master (
    output id_iw, ex_iw, ex_wb_en, ex_br_taken, ex_br_target, mem_busy,
    input  pc_stall, ifid_stall, ifid_flush, idex_bubble, pipe_freeze,
           pc_load, pc_target, stall_cnt, flush_cnt, state_o
  );

  modport slave (
    input  id_iw, ex_iw, ex_wb_en, ex_br_taken, ex_br_target, mem_busy,
    output pc_stall, ifid_stall, ifid_flush, idex_bubble, pipe_freeze,
           pc_load, pc_target, stall_cnt, flush_cnt, state_o
  );
endinterface

// File: rtl/rv32i_hazard_ctrl.sv
// 5-stage RV32I hazard controller: load-use stalls, EX redirects, memory-busy
// freezes, with saturating stall/flush counters.
module rv32i_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input logic               clk,
  input logic               reset,
  rv32i_hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  logic [4:0] ex_rd, id_rs1, id_rs2;
  logic [6:0] id_op;
  logic       ex_is_load, rs1_used, rs2_used, lu_hazard;

  logic        pc_stall, ifid_stall, ifid_flush, idex_bubble, pipe_freeze, pc_load;
  logic [31:0] pc_target;

  assign ex_rd      = hz.ex_iw[11:7];
  assign id_rs1     = hz.id_iw[19:15];
  assign id_rs2     = hz.id_iw[24:20];
  assign id_op      = hz.id_iw[6:0];
  assign ex_is_load = (hz.ex_iw[6:0] == OP_LOAD);
  assign rs1_used   = !(id_op == OP_LUI || id_op == OP_AUIPC || id_op == OP_JAL);
  assign rs2_used   = (id_op == OP_REG || id_op == OP_STORE || id_op == OP_BR);

  assign lu_hazard = ex_is_load && hz.ex_wb_en && (ex_rd != 5'd0) &&
                     ((rs1_used && id_rs1 == ex_rd) || (rs2_used && id_rs2 == ex_rd));

  // Fields of the instruction words the controller never looks at.
  logic unused_iw;
  assign unused_iw = ^{hz.id_iw[31:25], hz.id_iw[14:7], hz.ex_iw[31:12]};

  always_comb begin
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pipe_freeze = 1'b0;
    pc_load     = 1'b0;
    pc_target   = 32'd0;
    state_nxt   = RUN;
    if (!reset) begin
      case (state)
        // MEM_WAIT with busy released re-evaluates the frozen inputs as RUN
        RUN, MEM_WAIT: begin
          if (hz.mem_busy) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            pipe_freeze = 1'b1;
            state_nxt   = MEM_WAIT;
          end else if (hz.ex_br_taken) begin
            pc_load     = 1'b1;
            pc_target   = hz.ex_br_target;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            state_nxt   = FLUSH;
          end else if (lu_hazard) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_bubble = 1'b1;
            state_nxt   = RUN;
          end
        end
        // EX holds the injected bubble, so branch/hazard inputs are stale
        FLUSH: begin
          if (hz.mem_busy) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            pipe_freeze = 1'b1;
            state_nxt   = FLUSH;
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (pc_stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      if (pc_load  && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
    end
  end

  assign hz.pc_stall    = pc_stall;
  assign hz.ifid_stall  = ifid_stall;
  assign hz.ifid_flush  = ifid_flush;
  assign hz.idex_bubble = idex_bubble;
  assign hz.pipe_freeze = pipe_freeze;
  assign hz.pc_load     = pc_load;
  assign hz.pc_target   = pc_target;
  assign hz.stall_cnt   = stall_cnt;
  assign hz.flush_cnt   = flush_cnt;
  assign hz.state_o     = state;

endmodule

// File: tb/tb_rv32i_hazard_ctrl.sv
// Scoreboard bench for rv32i_hazard_ctrl: directed vectors push expectations,
// a negedge monitor pops and compares. A CNT_W=4 copy checks saturation.
module tb_rv32i_hazard_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rv32i_hazard_ctrl_if #(.CNT_W(16)) hz  ();
  rv32i_hazard_ctrl_if #(.CNT_W(4))  hz4 ();

  rv32i_hazard_ctrl #(.CNT_W(16)) dut  (.clk(clk), .reset(reset), .hz(hz.slave));
  rv32i_hazard_ctrl #(.CNT_W(4))  dut4 (.clk(clk), .reset(reset), .hz(hz4.slave));

  assign hz4.id_iw        = hz.id_iw;
  assign hz4.ex_iw        = hz.ex_iw;
  assign hz4.ex_wb_en     = hz.ex_wb_en;
  assign hz4.ex_br_taken  = hz.ex_br_taken;
  assign hz4.ex_br_target = hz.ex_br_target;
  assign hz4.mem_busy     = hz.mem_busy;

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] LW_X5    = 32'h0000_A283; // lw x5,0(x1)
  localparam logic [31:0] LW_X0    = 32'h0000_A003; // lw x0,0(x1)
  localparam logic [31:0] ADD_RS1  = 32'h0022_8333; // add x6,x5,x2
  localparam logic [31:0] ADD_RS2  = 32'h0051_0333; // add x6,x2,x5
  localparam logic [31:0] ADD_X0   = 32'h0020_0333; // add x6,x0,x2
  localparam logic [31:0] LUI_X5   = 32'h0002_82B7; // lui x5, rs1 field = 5

  // {pc_stall, ifid_stall, ifid_flush, idex_bubble, pipe_freeze, pc_load}
  localparam logic [5:0] C_NONE = 6'b000000;
  localparam logic [5:0] C_LU   = 6'b110100;
  localparam logic [5:0] C_BR   = 6'b001101;
  localparam logic [5:0] C_FRZ  = 6'b110010;

  typedef struct packed {
    logic [5:0]  ctl;
    logic [31:0] tgt;
    logic [1:0]  st;
    logic [15:0] scnt;
    logic [15:0] fcnt;
    logic [3:0]  scnt4;
  } exp_t;

  exp_t  q[$];
  string nq[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    es = 0, ef = 0;

  task automatic step(input string nm, input logic rst, input logic [31:0] id,
                      input logic [31:0] ex, input logic wb, input logic br,
                      input logic [31:0] tgt, input logic busy,
                      input logic [5:0] ctl, input logic [31:0] etgt,
                      input logic [1:0] est);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst; hz.id_iw = id; hz.ex_iw = ex; hz.ex_wb_en = wb;
    hz.ex_br_taken = br; hz.ex_br_target = tgt; hz.mem_busy = busy;
    e.ctl = ctl; e.tgt = etgt; e.st = est;
    e.scnt = 16'(es); e.fcnt = 16'(ef); e.scnt4 = (es > 15) ? 4'hF : 4'(es);
    q.push_back(e);
    nq.push_back(nm);
    if (rst) begin
      es = 0; ef = 0;
    end else begin
      es += int'(ctl[5]);
      ef += int'(ctl[0]);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t  e;
      exp_t  a;
      string nm;
      e  = q.pop_front();
      nm = nq.pop_front();
      a.ctl   = {hz.pc_stall, hz.ifid_stall, hz.ifid_flush, hz.idex_bubble,
                 hz.pipe_freeze, hz.pc_load};
      a.tgt   = hz.pc_target;
      a.st    = hz.state_o;
      a.scnt  = hz.stall_cnt;
      a.fcnt  = hz.flush_cnt;
      a.scnt4 = hz4.stall_cnt;
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL %s: got ctl=%b tgt=%h st=%0d scnt=%0d fcnt=%0d scnt4=%0d, want ctl=%b tgt=%h st=%0d scnt=%0d fcnt=%0d scnt4=%0d",
                 nm, a.ctl, a.tgt, a.st, a.scnt, a.fcnt, a.scnt4,
                 e.ctl, e.tgt, e.st, e.scnt, e.fcnt, e.scnt4);
      end
    end
  end

  initial begin
    reset = 1'b1; hz.id_iw = NOP; hz.ex_iw = NOP; hz.ex_wb_en = 1'b0;
    hz.ex_br_taken = 1'b0; hz.ex_br_target = 32'd0; hz.mem_busy = 1'b0;
    @(posedge clk);

    //   name          rst id       ex     wb br tgt            busy ctl     etgt           st
    step("rst_hold",    1, ADD_RS1, LW_X5, 1, 1, 32'h40,        1, C_NONE, 32'h0,         2'd0);
    step("lu_rs1",      0, ADD_RS1, LW_X5, 1, 0, 32'h0,         0, C_LU,   32'h0,         2'd0);
    step("lu_after",    0, ADD_RS1, NOP,   1, 0, 32'h0,         0, C_NONE, 32'h0,         2'd0);
    step("lu_rs2",      0, ADD_RS2, LW_X5, 1, 0, 32'h0,         0, C_LU,   32'h0,         2'd0);
    step("lu_rd_x0",    0, ADD_X0,  LW_X0, 1, 0, 32'h0,         0, C_NONE, 32'h0,         2'd0);
    step("lu_lui",      0, LUI_X5,  LW_X5, 1, 0, 32'h0,         0, C_NONE, 32'h0,         2'd0);
    step("lu_no_wb",    0, ADD_RS1, LW_X5, 0, 0, 32'h0,         0, C_NONE, 32'h0,         2'd0);
    step("br_take",     0, NOP,     NOP,   1, 1, 32'h40,        0, C_BR,   32'h40,        2'd0);
    step("flush_ign",   0, ADD_RS1, LW_X5, 1, 1, 32'h80,        0, C_NONE, 32'h0,         2'd2);
    step("flush_ret",   0, NOP,     NOP,   1, 0, 32'h0,         0, C_NONE, 32'h0,         2'd0);
    step("busy_1",      0, NOP,     NOP,   1, 1, 32'h100,       1, C_FRZ,  32'h0,         2'd0);
    step("busy_2",      0, NOP,     NOP,   1, 1, 32'h100,       1, C_FRZ,  32'h0,         2'd1);
    step("busy_3",      0, NOP,     NOP,   1, 1, 32'h100,       1, C_FRZ,  32'h0,         2'd1);
    step("busy_rel",    0, NOP,     NOP,   1, 1, 32'h100,       0, C_BR,   32'h100,       2'd1);
    step("post_rel",    0, NOP,     NOP,   1, 0, 32'h0,         0, C_NONE, 32'h0,         2'd2);
    step("idle",        0, NOP,     NOP,   1, 0, 32'h0,         0, C_NONE, 32'h0,         2'd0);
    step("lu_and_br",   0, ADD_RS1, LW_X5, 1, 1, 32'h200,       0, C_BR,   32'h200,       2'd0);
    step("flush_busy",  0, NOP,     NOP,   1, 1, 32'h300,       1, C_FRZ,  32'h0,         2'd2);
    step("flush_rel",   0, NOP,     NOP,   1, 1, 32'h300,       0, C_NONE, 32'h0,         2'd2);
    step("flush_done",  0, NOP,     NOP,   1, 0, 32'h0,         0, C_NONE, 32'h0,         2'd0);
    step("busy_a",      0, NOP,     NOP,   1, 1, 32'h400,       1, C_FRZ,  32'h0,         2'd0);
    step("rst_memwait", 1, NOP,     NOP,   1, 1, 32'h400,       1, C_NONE, 32'h0,         2'd1);
    step("after_rst1",  0, NOP,     NOP,   1, 0, 32'h0,         0, C_NONE, 32'h0,         2'd0);
    step("br_b",        0, NOP,     NOP,   1, 1, 32'h500,       0, C_BR,   32'h500,       2'd0);
    step("rst_flush",   1, NOP,     NOP,   1, 1, 32'h500,       0, C_NONE, 32'h0,         2'd2);
    step("after_rst2",  0, NOP,     NOP,   1, 0, 32'h0,         0, C_NONE, 32'h0,         2'd0);
    for (int i = 0; i < 20; i++)
      step($sformatf("sat_%0d", i), 0, ADD_RS1, LW_X5, 1, 0, 32'h0, 0, C_LU, 32'h0, 2'd0);
    step("sat_hold",    0, NOP,     NOP,   1, 0, 32'h0,         0, C_NONE, 32'h0,         2'd0);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending entries, want 0", q.size());
    end
    @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
